// File: rtl/as_jtag_host_pkg.sv
// as_jtag_host_pkg: shared types and TMS constants for the JTAG host.
`default_nettype none
package as_jtag_host_pkg;

   typedef enum logic [1:0] {
      OP_RESET    = 2'd0,
      OP_SHIFT_IR = 2'd1,
      OP_SHIFT_DR = 2'd2,
      OP_IDLE     = 2'd3
   } jtag_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TAIL  = 3'd3,
      ST_DONE  = 3'd4
   } jtag_state_e;

   localparam int unsigned jtag_len_width = 7;

   // TMS sequences, transmitted LSB first.
   localparam logic [3:0] ir_head = 4'b0011;
   localparam logic [2:0] dr_head = 3'b001;
   localparam logic [1:0] tail    = 2'b01;
   localparam logic [5:0] rst_seq = 6'b011111;

   function automatic logic [jtag_len_width-1:0] clamp_len(
      input logic [jtag_len_width-1:0] len,
      input logic [jtag_len_width-1:0] max_len
   );
      return (len > max_len) ? max_len : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/as_jtag_host_tckgen.sv
// as_jtag_host_tckgen: TCK divider with period-start and sample strobes; rev 1.0.
`default_nettype none
module as_jtag_tckgen #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tck_o,
   output logic fall_stb_o,
   output logic rise_stb_o
);
   localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] c_div_m1 = CW'(TCK_DIV - 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic          tck_d, tck_q;
   logic          wrap;

   assign wrap       = en_i && (cnt_q == '0);
   assign rise_stb_o = wrap && !tck_q;
   assign fall_stb_o = wrap && tck_q;
   assign tck_o      = tck_q;

   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (!en_i) begin
         cnt_d = c_div_m1;
         tck_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d = c_div_m1;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= c_div_m1;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/as_jtag_host.sv
// as_jtag_host: runs one complete TAP operation per command, RTI to RTI; rev 1.0.
`default_nettype none
module as_jtag_host
   import as_jtag_host_pkg::*;
#(
   parameter int unsigned TCK_DIV  = 2,
   parameter int unsigned IR_WIDTH = 8,
   parameter int unsigned DR_MAX   = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [1:0]                cmd_op_i,
   input  logic [jtag_len_width-1:0] cmd_len_i,
   input  logic [DR_MAX-1:0]         cmd_data_i,
   output logic                      rsp_valid_o,
   output logic [DR_MAX-1:0]         rsp_data_o,
   output logic                      tck_o,
   output logic                      tms_o,
   output logic                      tdi_o,
   input  logic                      tdo_i
);
   localparam int unsigned IW = $clog2(DR_MAX);
   localparam logic [jtag_len_width-1:0] c_dr_max = jtag_len_width'(DR_MAX);
   localparam logic [jtag_len_width-1:0] c_ir_len = jtag_len_width'(IR_WIDTH);

   jtag_state_e state_d, state_q;
   jtag_op_e    op_d, op_q, cmd_op;
   logic [jtag_len_width-1:0] len_d, len_q, cnt_d, cnt_q, len_c, idx;
   logic [5:0]        seq_d, seq_q;
   logic [DR_MAX-1:0] sh_d, sh_q, cap_d, cap_q, rsp_d, rsp_q;
   logic tms_d, tms_q, tdi_d, tdi_q;
   logic accept, tck_en, fall_stb, rise_stb, last, is_shift_op;

   as_jtag_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
      .clk        (clk),
      .rst        (rst),
      .en_i       (tck_en),
      .tck_o      (tck_o),
      .fall_stb_o (fall_stb),
      .rise_stb_o (rise_stb)
   );

   assign cmd_op      = jtag_op_e'(cmd_op_i);
   assign len_c       = clamp_len(cmd_len_i, c_dr_max);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign last        = fall_stb && (cnt_q == '0);
   assign is_shift_op = (op_q == OP_SHIFT_IR) || (op_q == OP_SHIFT_DR);
   assign idx         = len_q - 1'b1 - cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_RESET;
         len_q   <= '0;
         cnt_q   <= '0;
         seq_q   <= '0;
         sh_q    <= '0;
         cap_q   <= '0;
         rsp_q   <= '0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         sh_q    <= sh_d;
         cap_q   <= cap_d;
         rsp_q   <= rsp_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            if ((cmd_op == OP_SHIFT_DR || cmd_op == OP_IDLE) && len_c == '0)
               state_d = ST_DONE;
            else
               state_d = ST_HEAD;
         end
         ST_HEAD:  if (last) state_d = is_shift_op ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (last) state_d = ST_TAIL;
         ST_TAIL:  if (last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state_q == ST_IDLE) && !rst;
      rsp_valid_o = (state_q == ST_DONE);
      tck_en      = (state_q == ST_HEAD) || (state_q == ST_SHIFT) || (state_q == ST_TAIL);
      rsp_data_o  = rsp_q;
      tms_o       = tms_q;
      tdi_o       = tdi_q;
   end

   always_comb begin
      op_d  = op_q;
      len_d = len_q;
      cnt_d = cnt_q;
      seq_d = seq_q;
      sh_d  = sh_q;
      cap_d = cap_q;
      rsp_d = rsp_q;
      tms_d = tms_q;
      tdi_d = tdi_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            op_d  = cmd_op;
            sh_d  = cmd_data_i;
            cap_d = '0;
            tdi_d = 1'b0;
            case (cmd_op)
               OP_RESET: begin
                  len_d = '0;  cnt_d = 7'd5;
                  tms_d = rst_seq[0];  seq_d = 6'(rst_seq[5:1]);
               end
               OP_SHIFT_IR: begin
                  len_d = c_ir_len;  cnt_d = 7'd3;
                  tms_d = ir_head[0];  seq_d = 6'(ir_head[3:1]);
               end
               OP_SHIFT_DR: begin
                  len_d = len_c;  cnt_d = 7'd2;
                  seq_d = 6'(dr_head[2:1]);
                  if (len_c != '0) tms_d = dr_head[0];
               end
               default: begin
                  len_d = '0;  cnt_d = len_c - 1'b1;
                  seq_d = '0;
                  if (len_c != '0) tms_d = 1'b0;
               end
            endcase
         end
         ST_HEAD: if (fall_stb) begin
            if (cnt_q != '0) begin
               tms_d = seq_q[0];
               seq_d = seq_q >> 1;
               cnt_d = cnt_q - 1'b1;
            end else if (is_shift_op) begin
               tms_d = (len_q == 7'd1);
               tdi_d = sh_q[0];
               sh_d  = sh_q >> 1;
               cnt_d = len_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            if (rise_stb) cap_d[idx[IW-1:0]] = tdo_i;
            if (fall_stb) begin
               if (cnt_q != '0) begin
                  // Bit after this one is the last: raise TMS to leave Shift.
                  tms_d = (cnt_q == 7'd1);
                  tdi_d = sh_q[0];
                  sh_d  = sh_q >> 1;
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  tms_d = tail[0];
                  seq_d = 6'(tail[1]);
                  tdi_d = 1'b0;
                  cnt_d = 7'd1;
               end
            end
         end
         ST_TAIL: if (fall_stb && cnt_q != '0) begin
            tms_d = seq_q[0];
            seq_d = seq_q >> 1;
            cnt_d = cnt_q - 1'b1;
         end
         default: ;
      endcase
      if (state_d == ST_DONE && state_q != ST_DONE)
         rsp_d = (state_q == ST_IDLE) ? '0 : cap_d;
   end
endmodule
`default_nettype wire

// File: tb/tb_as_jtag_host.sv
// tb_as_jtag_host: scoreboard bench with a TAP target model and a TDI->TDO loopback.
`default_nettype none
module tb_as_jtag_host;
   import as_jtag_host_pkg::*;

   localparam logic [31:0] IDCODE = 32'h4BA0_0477;
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                  EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                  PAIR = 13, EX2IR = 14, UPIR = 15;

   logic        clk = 0, rst = 1;
   logic        cmd_valid = 0, cmd_ready, rsp_valid, tck, tms, tdi, tdo;
   logic [1:0]  cmd_op = 0;
   logic [6:0]  cmd_len = 0;
   logic [63:0] cmd_data = 0, rsp_data;

   as_jtag_host #(.TCK_DIV(2), .IR_WIDTH(8), .DR_MAX(64)) dut (
      .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0, last_acc = 0, np = 0, viol = 0;
   logic [127:0] tms_v = '0, tdi_v = '0;
   logic ptms = 1'b1, ptdi = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- TAP target model ----------------
   int          tap_st = TLR;
   logic [7:0]  tap_ir = 8'h01, ir_sh = 8'h00;
   logic [31:0] dr_sh = 32'h0;
   logic        tap_tdo = 1'b0, loop_en = 1'b0;
   assign tdo = loop_en ? tdi : tap_tdo;

   function automatic int tap_next(input int s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR, SHDR: return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PADR;
         PADR:  return m ? EX2DR : PADR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR, UPIR: return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR, SHIR: return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAIR;
         PAIR:  return m ? EX2IR : PAIR;
         default: return m ? UPIR : SHIR;
      endcase
   endfunction

   always @(posedge tck) begin
      if (np < 128) begin tms_v[np] = tms; tdi_v[np] = tdi; end
      np++;
      case (tap_st)
         TLR:   tap_ir = 8'h01;
         CAPDR: dr_sh = (tap_ir == 8'h01) ? IDCODE : 32'h0;
         SHDR:  dr_sh = {tdi, dr_sh[31:1]};
         CAPIR: ir_sh = 8'h01;
         SHIR:  ir_sh = {tdi, ir_sh[7:1]};
         UPIR:  tap_ir = ir_sh;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
   end

   always @(negedge tck)
      tap_tdo <= (tap_st == SHDR) ? dr_sh[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;

   // TMS/TDI must hold steady while TCK is high.
   always @(negedge clk) begin
      if (tck && (tms !== ptms || tdi !== ptdi)) viol++;
      ptms = tms;
      ptdi = tdi;
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [63:0] data; int cyc; } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got data %h at cycle %0d, expected none", rsp_data, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            chk("tck_low_at_rsp", 64'(tck), 64'd0);
         end
      end
   end

   task automatic send(input jtag_op_e op, input int len, input logic [63:0] data,
                       input logic [63:0] exp, input int nper, input bit push);
      int t = 0;
      @(negedge clk);
      np = 0; tms_v = '0; tdi_v = '0;
      cmd_valid = 1; cmd_op = op; cmd_len = 7'(len); cmd_data = data;
      while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", cmd_ready, t);
         cmd_valid = 0;
         return;
      end
      last_acc = cyc;
      if (push) sb.push_back('{data: exp, cyc: cyc + 4 * nper + 1});
      @(posedge clk);
   endtask

   task automatic drop();
      @(negedge clk);
      cmd_valid = 0; cmd_data = '1; cmd_len = 7'h7F;
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   int acc_a;

   initial begin
      repeat (3) @(negedge clk);
      chk("ready_in_rst", 64'(cmd_ready), 64'd0);
      rst = 0;
      @(negedge clk);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_tck", 64'(tck), 64'd0);
      chk("rst_tms", 64'(tms), 64'd1);
      chk("rst_tdi", 64'(tdi), 64'd0);
      chk("rst_rsp", {63'd0, rsp_valid} | rsp_data, 64'd0);

      // TAP reset: 6 periods
      send(OP_RESET, 0, 64'hFFFF, 64'h0, 6, 1); drop(); wait_done();
      chk("reset_np", 64'(np), 64'd6);
      chk("reset_tms", tms_v[63:0], 64'h1F);
      chk("reset_tap_rti", 64'(tap_st), 64'(RTI));

      // Loopback DR shift of 0xA5: 13 periods
      loop_en = 1;
      send(OP_SHIFT_DR, 8, 64'hA5, 64'hA5, 13, 1); drop(); wait_done();
      chk("dr8_np", 64'(np), 64'd13);
      chk("dr8_tms", tms_v[63:0], 64'h0C01);
      chk("dr8_tdi", tdi_v[63:0], 64'h528);

      // IDCODE read after a TAP reset
      loop_en = 0;
      send(OP_RESET, 0, 64'h0, 64'h0, 6, 1); drop(); wait_done();
      send(OP_SHIFT_DR, 32, 64'h0, {32'h0, IDCODE}, 37, 1); drop(); wait_done();
      chk("idcode_np", 64'(np), 64'd37);
      chk("idcode_tap_rti", 64'(tap_st), 64'(RTI));

      // IR shift ignores cmd_len; captured IR value is 0x01
      send(OP_SHIFT_IR, 3, 64'h02, 64'h01, 14, 1); drop(); wait_done();
      chk("ir_np", 64'(np), 64'd14);
      chk("ir_value", 64'(tap_ir), 64'h02);
      chk("ir_tap_rti", 64'(tap_st), 64'(RTI));

      // Zero-length DR: no TCK, response one cycle after accept
      send(OP_SHIFT_DR, 0, 64'hFF, 64'h0, 0, 1); drop(); wait_done();
      chk("dr0_np", 64'(np), 64'd0);

      // Idle clocks
      send(OP_IDLE, 5, 64'hFF, 64'h0, 5, 1); drop(); wait_done();
      chk("idle_np", 64'(np), 64'd5);
      chk("idle_tms", tms_v[63:0], 64'h0);
      chk("idle_tap_rti", 64'(tap_st), 64'(RTI));

      // Length 100 clamps to 64 bits: 69 periods
      loop_en = 1;
      send(OP_SHIFT_DR, 100, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 69, 1);
      drop(); wait_done();
      chk("dr100_np", 64'(np), 64'd69);

      // Back-to-back with cmd_valid held high
      send(OP_SHIFT_DR, 8, 64'h3C, 64'h3C, 13, 1);
      acc_a = last_acc;
      send(OP_IDLE, 2, 64'h0, 64'h0, 2, 1);
      chk("b2b_accept", 64'(last_acc), 64'(acc_a + 54));
      drop(); wait_done();

      // rst in the middle of a 64-bit shift aborts without a response
      send(OP_SHIFT_DR, 64, 64'h5555_AAAA_5555_AAAA, 64'h0, 69, 0); drop();
      repeat (40) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("abort_tck", 64'(tck), 64'd0);
      chk("abort_tms", 64'(tms), 64'd1);
      chk("abort_tdi", 64'(tdi), 64'd0);
      chk("abort_rsp", {63'd0, rsp_valid} | rsp_data, 64'd0);
      chk("abort_ready_in_rst", 64'(cmd_ready), 64'd0);
      rst = 0;
      @(negedge clk);
      chk("abort_ready_after", 64'(cmd_ready), 64'd1);
      repeat (300) @(negedge clk);

      chk("tms_tdi_stable_hi", 64'(viol), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
